// File: rtl/ni_inject_queue_pkg.sv
// rtl/ni_inject_queue_pkg.sv - shared staging-word layout and helpers for the injection NI
// Purpose: field positions of the 22-bit staging word {valid,vc[4:0],flit[15:0]}
//          shared with the router, plus the round-robin start helper.
// Ports:   none (package).
package ni_inject_queue_pkg;

   localparam int FLIT_W     = 16;
   localparam int VC_W       = 5;
   localparam int NUMVCS_W   = 6;
   localparam int FLIT_VC_LO = FLIT_W;
   localparam int FLIT_VC_HI = FLIT_VC_LO + VC_W - 1;
   localparam int FLIT_VALID = FLIT_VC_HI + 1;
   localparam int STAGE_W    = FLIT_VALID + 1;

   // First VC examined by the arbiter: (rr + 1) mod nv. rr may exceed nv
   // after numvcs is lowered, so a true modulo is used rather than a wrap test.
   function automatic logic [VC_W-1:0] rr_start(input logic [VC_W-1:0] rr,
                                                input logic [NUMVCS_W-1:0] nv);
      if (nv == '0) begin
         return '0;
      end
      return VC_W'(({2'b00, rr} + 7'd1) % {1'b0, nv});
   endfunction

endpackage

// File: rtl/ni_vc_fifo.sv
// rtl/ni_vc_fifo.sv - single-VC flit FIFO for the injection NI
// Purpose: DEPTH-deep FIFO with combinational head; push into a full FIFO or
//          pop from an empty FIFO is ignored. Push and pop may coincide.
// Ports:   clk, rst_n (async active-low), push, pop, wdata[WIDTH-1:0] in;
//          full, empty, head[WIDTH-1:0] out.
module ni_vc_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == FULL_CNT);
   assign empty  = (r_count == '0);
   assign head   = r_mem[r_rd_ptr];
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   // Storage is not reset; pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ni_inject_queue.sv
// rtl/ni_inject_queue.sv - injection-port network interface with per-VC queues
// Purpose: buffers generator flits per VC, picks one eligible VC round-robin on
//          each adv pulse and holds the staging word for router port 0.
// Ports:   clk, rst_n (async active-low); numvcs[5:0] active VC count;
//          wr_en/wr_vc[4:0]/wr_flit[15:0] generator write, wr_full[MAXVC] out;
//          adv network-cycle strobe, can_inject[MAXVC] router buffer free;
//          out_staging[21:0], inj_count[CNT_W], overflow (sticky), idle out.
module ni_inject_queue
   import ni_inject_queue_pkg::*;
#(
   parameter int MAXVC      = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUMVCS_W-1:0] numvcs,
   input  logic                wr_en,
   input  logic [VC_W-1:0]     wr_vc,
   input  logic [FLIT_W-1:0]   wr_flit,
   output logic [MAXVC-1:0]    wr_full,
   input  logic                adv,
   input  logic [MAXVC-1:0]    can_inject,
   output logic [STAGE_W-1:0]  out_staging,
   output logic [CNT_W-1:0]    inj_count,
   output logic                overflow,
   output logic                idle
);

   logic [NUMVCS_W-1:0] w_nv;
   logic [VC_W-1:0]     w_start;
   logic [MAXVC-1:0]    w_active;
   logic [MAXVC-1:0]    w_push;
   logic [MAXVC-1:0]    w_pop;
   logic [MAXVC-1:0]    w_full;
   logic [MAXVC-1:0]    w_empty;
   logic [MAXVC-1:0]    w_elig;
   logic [FLIT_W-1:0]   w_head [MAXVC];
   logic                w_found;
   logic [VC_W-1:0]     w_win;
   logic [FLIT_W-1:0]   w_win_head;

   logic [STAGE_W-1:0]  r_stage;
   logic [VC_W-1:0]     r_rr_ptr;
   logic [VC_W-1:0]     r_last_vc;
   logic                r_last_valid;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ovf;

   // numvcs above the physical VC count is clamped so no out-of-range VC is ever served.
   assign w_nv    = (numvcs > NUMVCS_W'(MAXVC)) ? NUMVCS_W'(MAXVC) : numvcs;
   assign w_start = rr_start(r_rr_ptr, w_nv);

   for (genvar v = 0; v < MAXVC; v++) begin : g_vc
      assign w_active[v] = (NUMVCS_W'(v) < w_nv);
      // Full is the pre-edge value, so a write to a full VC is dropped even if it pops now.
      assign w_push[v]   = wr_en && (wr_vc == VC_W'(v)) && w_active[v] && !w_full[v];
      assign w_pop[v]    = adv && w_found && (w_win == VC_W'(v));
      // The VC issued on the previous adv is skipped: can_inject does not yet reflect it.
      assign w_elig[v]   = w_active[v] && !w_empty[v] && can_inject[v] &&
                           !(r_last_valid && (r_last_vc == VC_W'(v)));

      ni_vc_fifo #(
         .WIDTH (FLIT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (w_push[v]),
         .pop   (w_pop[v]),
         .wdata (wr_flit),
         .full  (w_full[v]),
         .empty (w_empty[v]),
         .head  (w_head[v])
      );
   end

   // Round-robin pick: the eligible VC with the smallest distance (mod nv)
   // from the start position wins.
   always_comb begin
      int s;
      int nv;
      int d;
      int best;
      s          = int'(w_start);
      nv         = int'(w_nv);
      d          = 0;
      best       = MAXVC;
      w_found    = 1'b0;
      w_win      = '0;
      w_win_head = '0;
      for (int v = 0; v < MAXVC; v++) begin
         d = (v >= s) ? (v - s) : (v + nv - s);
         if (w_elig[v] && (d < best)) begin
            best       = d;
            w_found    = 1'b1;
            w_win      = VC_W'(v);
            w_win_head = w_head[v];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage      <= '0;
         r_rr_ptr     <= '0;
         r_last_vc    <= '0;
         r_last_valid <= 1'b0;
         r_cnt        <= '0;
         r_ovf        <= 1'b0;
      end else begin
         if (wr_en && (w_push == '0)) begin
            r_ovf <= 1'b1;
         end
         if (adv) begin
            r_last_valid <= w_found;
            if (w_found) begin
               r_stage   <= {1'b1, w_win, w_win_head};
               r_rr_ptr  <= w_win;
               r_last_vc <= w_win;
               r_cnt     <= r_cnt + 1'b1;
            end else begin
               r_stage   <= '0;
            end
         end
      end
   end

   assign wr_full     = w_full;
   assign out_staging = r_stage;
   assign inj_count   = r_cnt;
   assign overflow    = r_ovf;
   assign idle        = (&w_empty) && !r_stage[FLIT_VALID];

endmodule
